// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;
  localparam int SUB_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/serial_sub_if.sv
// Start/done handshake bundle for serial_subtractor; ovf exists only with SERIAL_SUB_OVF_EN.
interface serial_sub_if #(parameter int N = serial_sub_pkg::SUB_W);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/full_subtractor_cell.sv
// Gate-level full subtractor: d = x - y - bi, bo = borrow out.
module full_subtractor_cell (
  output wire d,
  output wire bo,
  input  wire x,
  input  wire y,
  input  wire bi
);
  wire x_xor_y;
  wire x_n;
  wire xy_n;
  wire t_xy;
  wire t_bi;

  xor g_x0 (x_xor_y, x, y);
  xor g_x1 (d, x_xor_y, bi);
  not g_n0 (x_n, x);
  not g_n1 (xy_n, x_xor_y);
  and g_a0 (t_xy, x_n, y);
  and g_a1 (t_bi, xy_n, bi);
  or  g_o0 (bo, t_xy, t_bi);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, one bit per clock with borrow flop.
// SERIAL_SUB_OVF_EN adds a registered signed-overflow output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N  = SUB_W,
  parameter int CW = $clog2(N)
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave io
);
  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           br_q, br_d;
  logic [N-1:0]   diff_q, diff_d;
  logic           bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  logic d_bit;
  logic nb;

  full_subtractor_cell u_cell (
    .d  (d_bit),
    .bo (nb),
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (br_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (io.start) begin
          state_d = SHIFT;
          a_d     = io.a;
          b_d     = io.b;
          br_d    = io.bin;
          cnt_d   = '0;
          diff_d  = '0;
          bout_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = nb;
        diff_d = {d_bit, diff_q[N-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          state_d = DONE;
          bout_d  = nb;
`ifdef SERIAL_SUB_OVF_EN
          // br_q is the borrow into the MSB stage on the last shift
          ovf_d   = br_q ^ nb;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign io.busy = (state_q == SHIFT);
  assign io.done = (state_q == DONE);
  assign io.diff = diff_q;
  assign io.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign io.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at N=4 and N=8.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_sub_if #(.N(4)) if4 ();
  serial_sub_if #(.N(8)) if8 ();

  serial_subtractor #(.N(4)) dut4 (.clk(clk), .rst(rst), .io(if4));
  serial_subtractor #(.N(8)) dut8 (.clk(clk), .rst(rst), .io(if8));

  task automatic test_reset();
    if4.start = 0; if4.a = '0; if4.b = '0; if4.bin = 0;
    if8.start = 0; if8.a = '0; if8.b = '0; if8.bin = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({if4.busy, if4.done, if4.diff, if4.bout} !== 7'b0) begin
      failures++;
      $display("FAIL reset4 got busy=%b done=%b diff=%h bout=%b want all 0", if4.busy, if4.done, if4.diff, if4.bout);
    end
    checks++;
    if ({if8.busy, if8.done, if8.diff, if8.bout} !== 11'b0) begin
      failures++;
      $display("FAIL reset8 got busy=%b done=%b diff=%h bout=%b want all 0", if8.busy, if8.done, if8.diff, if8.bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (if4.ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf got %b want 0", if4.ovf);
    end
`endif
    rst = 0;
    @(negedge clk);
  endtask

  // One N=4 op: checks latency, busy length, result and that done is a pulse.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi,
                     input logic [3:0] exp_d, input logic exp_bo, input string nm);
    int cyc;
    int busy_n;
    cyc = 1;
    busy_n = 0;
    if4.start = 1; if4.a = a; if4.b = b; if4.bin = bi;
    @(negedge clk);
    if4.start = 0;
    while (!if4.done && cyc < 20) begin
      if (if4.busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 5 || busy_n !== 4) begin
      failures++;
      $display("FAIL %s_latency got done_cyc=%0d busy=%0d want 5/4", nm, cyc, busy_n);
    end
    checks++;
    if (if4.diff !== exp_d || if4.bout !== exp_bo) begin
      failures++;
      $display("FAIL %s_result got diff=%h bout=%b want diff=%h bout=%b", nm, if4.diff, if4.bout, exp_d, exp_bo);
    end
    @(negedge clk);
    checks++;
    if (if4.done !== 1'b0 || if4.busy !== 1'b0 || if4.diff !== exp_d || if4.bout !== exp_bo) begin
      failures++;
      $display("FAIL %s_hold got done=%b busy=%b diff=%h bout=%b want 0/0/%h/%b", nm, if4.done, if4.busy, if4.diff, if4.bout, exp_d, exp_bo);
    end
  endtask

  task automatic test_basic();
    op4(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, "sub9_3");
    op4(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, "sub3_9");
    op4(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, "sub0_0_bin");
    op4(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, "subF_F_bin");
    op4(4'hF, 4'h0, 1'b0, 4'hF, 1'b0, "subF_0");
  endtask

  task automatic test_back_to_back();
    logic exp_busy, exp_done;
    if4.start = 1; if4.a = 4'd5; if4.b = 4'd2; if4.bin = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      exp_done = (cyc == 5 || cyc == 10);
      exp_busy = !exp_done;
      checks++;
      if (if4.busy !== exp_busy || if4.done !== exp_done) begin
        failures++;
        $display("FAIL b2b_cyc%0d got busy=%b done=%b want %b/%b", cyc, if4.busy, if4.done, exp_busy, exp_done);
      end
      if (exp_done) begin
        checks++;
        if (if4.diff !== 4'd3 || if4.bout !== 1'b0) begin
          failures++;
          $display("FAIL b2b_result%0d got diff=%h bout=%b want 3/0", cyc, if4.diff, if4.bout);
        end
      end
      // operand changes mid-SHIFT must not disturb the op in flight
      if (cyc == 2) begin if4.a = 4'd0; if4.b = 4'd0; end
      if (cyc == 4) begin if4.a = 4'd5; if4.b = 4'd2; end
      if (cyc == 10) if4.start = 0;
    end
    @(negedge clk);
    checks++;
    if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.diff !== 4'd3) begin
      failures++;
      $display("FAIL b2b_idle got busy=%b done=%b diff=%h want 0/0/3", if4.busy, if4.done, if4.diff);
    end
  endtask

  task automatic test_reset_mid_shift();
    int seen_done;
    seen_done = 0;
    if4.start = 1; if4.a = 4'd9; if4.b = 4'd3; if4.bin = 0;
    @(negedge clk);
    if4.start = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.diff !== 4'd0 || if4.bout !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid got busy=%b done=%b diff=%h bout=%b want all 0", if4.busy, if4.done, if4.diff, if4.bout);
    end
    repeat (8) begin
      @(negedge clk);
      if (if4.done || if4.busy) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      failures++;
      $display("FAIL rst_mid_quiet got %0d active cycles want 0", seen_done);
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    op4(4'h8, 4'h1, 1'b0, 4'h7, 1'b0, "ovf8_1");
    checks++;
    if (if4.ovf !== 1'b1) begin failures++; $display("FAIL ovf8_1 got %b want 1", if4.ovf); end
    op4(4'h7, 4'hF, 1'b0, 4'h8, 1'b1, "ovf7_F");
    checks++;
    if (if4.ovf !== 1'b1) begin failures++; $display("FAIL ovf7_F got %b want 1", if4.ovf); end
    op4(4'h5, 4'h2, 1'b0, 4'h3, 1'b0, "ovf5_2");
    checks++;
    if (if4.ovf !== 1'b0) begin failures++; $display("FAIL ovf5_2 got %b want 0", if4.ovf); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] a, b;
    logic       bi;
    logic [8:0] exp;
    int cyc;
    int bad;
    int to;
`ifdef SERIAL_SUB_OVF_EN
    int sr;
    logic exp_ovf;
`endif
    bad = 0;
    to = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
      if (i == 0) begin a = 8'h00; b = 8'hFF; bi = 1'b1; end
      if (i == 1) begin a = 8'hFF; b = 8'h00; bi = 1'b0; end
      exp = {1'b0, a} - {1'b0, b} - {8'b0, bi};
      if8.start = 1; if8.a = a; if8.b = b; if8.bin = bi;
      @(negedge clk);
      if8.start = 0;
      cyc = 1;
      while (!if8.done && cyc < 30) begin @(negedge clk); cyc++; end
      checks++;
      if (!if8.done) begin
        failures++; to++;
        if (to < 5) $display("FAIL rand_timeout op%0d got no done want done", i);
      end else if ({if8.bout, if8.diff} !== exp || cyc !== 9) begin
        failures++; bad++;
        if (bad < 5) $display("FAIL rand_op%0d a=%h b=%h bin=%b got %h cyc=%0d want %h cyc=9", i, a, b, bi, {if8.bout, if8.diff}, cyc, exp);
      end
`ifdef SERIAL_SUB_OVF_EN
      sr = $signed(a) - $signed(b) - int'(bi);
      exp_ovf = (sr < -128 || sr > 127);
      checks++;
      if (if8.ovf !== exp_ovf) begin
        failures++; bad++;
        if (bad < 5) $display("FAIL rand_ovf%0d a=%h b=%h bin=%b got %b want %b", i, a, b, bi, if8.ovf, exp_ovf);
      end
`endif
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid_shift();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor with a start/done handshake: computes diff = a - b - bin, one bit per clock, LSB first, plus borrow-out.
- Inverse-direction companion to the team's structural full-adder cell. The arithmetic core is a gate-level full-subtractor cell; the block adds sequencing, shift registers and a borrow flip-flop.
- Sits in the lab datapath as a low-area arithmetic unit behind a simple controller.

Parameters:
- N, 8, operand and result width in bits (N >= 2).
- CW, $clog2(N), bit-counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on a clk edge when the block is in IDLE or DONE.
- a  input  N  minuend; captured with an accepted start.
- b  input  N  subtrahend; captured with an accepted start.
- bin  input  1  borrow-in; captured with an accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; diff and bout are valid.
- diff  output  N  difference; held until the next accepted start.
- bout  output  1  final borrow-out; held with diff.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; counter=0, borrow FF=0.
- Reset overrides everything, including mid-SHIFT; the partial result is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on start=1:
  - load shift regs with a and b; borrow FF <= bin; counter <= 0; busy <= 1.
  - diff is cleared to 0 on load.
- SHIFT, each edge:
  - full-subtractor cell computes d = a0 ^ b0 ^ br and nb = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into diff MSB, with diff shifting right; a and b regs shift right; br <= nb; counter++.
- SHIFT -> DONE on the edge where counter == N-1: busy <= 0, done <= 1, bout <= nb.
- DONE -> IDLE next edge: done <= 0.
  - If start=1 in DONE, go straight to SHIFT with a new load (back-to-back).
- Latency: start accepted at edge E0; done=1 in the cycle after edge E0+N; throughput is one op per N+1 cycles.
- start while in SHIFT is ignored, with no effect on operands or the counter.
- Arithmetic is modulo 2^N. bout=1 iff a < b + bin as unsigned values.
- diff and bout never change except on load (diff cleared), during SHIFT, or on reset.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - port ovf exists; an extra FF keeps the borrow into the MSB stage.
  - ovf <= (borrow into MSB) ^ (borrow out of MSB), registered at the DONE transition; cleared on load and on reset.
  - ovf=1 means a - b - bin overflowed as two's-complement.
- Undefined: no ovf port, no extra FF; behaviour otherwise identical.

Decomposition:
- Package serial_sub_pkg:
  - state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - default width constant SUB_W=8.
- Sub-module full_subtractor_cell(output d, bo, input x, y, bi): structural gate-level, using xor/and/or/not primitives. One instance, combinational.

Test Plan:
- N=4, a=9, b=3, bin=0, start pulse -> busy high 4 cycles; done pulse in cycle 5 after start; diff=6, bout=0.
- N=4, a=3, b=9, bin=0 -> diff=4'hA, bout=1. Then a=0, b=0, bin=1 -> diff=4'hF, bout=1.
- N=4, start held high continuously with a=5, b=2 -> start ignored during SHIFT; results at done; a new op loads from DONE with no IDLE gap (period N+1=5 cycles).
- N=4, a=9, b=3, start; assert rst for 1 cycle after 2 SHIFT cycles -> next cycle state IDLE, busy=0, done=0, diff=0, bout=0; no done pulse follows.
- With SERIAL_SUB_OVF_EN, N=4:
  - a=4'h8, b=1 -> diff=7, ovf=1.
  - a=4'h7, b=4'hF -> diff=8, ovf=1.
  - a=5, b=2 -> ovf=0.
- Randomized sweep, N=8, 1000 ops -> {bout,diff} == {1'b0,a} - b - bin (9-bit) on every done.
